// File: rtl/mem_word_adapter.sv
// Word-access front end for a byte-wide, negedge-clocked RAM.
// Splits one word request into WORD_BYTES little-endian byte beats and reassembles the read data.
module mem_word_adapter #(
    parameter int WIDTH         = 8,
    parameter int RAM_ADDR_BITS = 8,
    parameter int WORD_BYTES    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [RAM_ADDR_BITS-1:0]         req_addr,
    input  logic [WIDTH*WORD_BYTES-1:0]      req_wdata,
    output logic                             resp_valid,
    output logic [WIDTH*WORD_BYTES-1:0]      resp_rdata,
    output logic                             mem_en,
    output logic                             mem_write,
    output logic [RAM_ADDR_BITS-1:0]         mem_adr,
    output logic [WIDTH-1:0]                 mem_wdata,
    input  logic [WIDTH-1:0]                 mem_rdata
);

    localparam int W      = WIDTH * WORD_BYTES;
    localparam int BEAT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [BEAT_W-1:0]        beat;
    logic                     write_lat;
    logic [RAM_ADDR_BITS-1:0] base_lat;
    logic [W-1:0]             wdata_lat;
    logic [W-1:0]             rdata_asm;

    // Control state and the response word; both must come out of reset cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            rdata_asm <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        beat <= '0;
                    end
                end
                BEAT: begin
                    // The RAM has already answered this beat on the preceding negedge.
                    rdata_asm[beat*WIDTH +: WIDTH] <= mem_rdata;
                    beat                           <= beat + BEAT_W'(1);
                end
                default: begin
                    beat <= beat;
                end
            endcase
        end
    end

    // Request payload; only observed while in BEAT, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && !reset) begin
            write_lat <= req_write;
            base_lat  <= req_addr;
            wdata_lat <= req_wdata;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_write  = 1'b0;
        mem_adr    = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = BEAT;
                end
            end
            BEAT: begin
                mem_en    = 1'b1;
                mem_write = write_lat;
                // Address arithmetic wraps naturally at the RAM address width.
                mem_adr   = base_lat + RAM_ADDR_BITS'(beat);
                mem_wdata = wdata_lat[beat*WIDTH +: WIDTH];
                if (beat == LAST_BEAT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign resp_rdata = rdata_asm;

endmodule

// File: tb/tb_mem_word_adapter.sv
// Directed bench for mem_word_adapter with a behavioural negedge byte RAM
// that reads the old contents before applying a write.
module tb_mem_word_adapter;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_write;
    logic [7:0]  mem_adr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [256];
    int          total;
    int          fails;
    int          resp_cnt;
    int          en_cnt;

    mem_word_adapter #(
        .WIDTH(8),
        .RAM_ADDR_BITS(8),
        .WORD_BYTES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_en(mem_en),
        .mem_write(mem_write),
        .mem_adr(mem_adr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: read-before-write on the falling edge.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            en_cnt    = en_cnt + 1;
            mem_rdata = ram[mem_adr];
            if (mem_write === 1'b1) begin
                ram[mem_adr] = mem_wdata;
            end
        end
    end

    always @(posedge clk) begin
        if (resp_valid === 1'b1) begin
            resp_cnt = resp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request, called from an IDLE sample point.
    task automatic xact(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
        int start_cnt;
        logic [7:0] ea;
        start_cnt = resp_cnt;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        req_addr  = ~a;
        req_wdata = ~wd;
        req_write = ~wr;
        for (int i = 0; i < 4; i++) begin
            ea = a + 8'(i);
            chk("beat_en", {31'b0, mem_en}, 32'd1);
            chk("beat_wr", {31'b0, mem_write}, {31'b0, wr});
            chk("beat_adr", {24'b0, mem_adr}, {24'b0, ea});
            if (wr) chk("beat_wdata", {24'b0, mem_wdata}, {24'b0, wd[i*8 +: 8]});
            chk("beat_ready", {31'b0, req_ready}, 32'd0);
            chk("beat_resp", {31'b0, resp_valid}, 32'd0);
            step();
        end
        chk("done_resp", {31'b0, resp_valid}, 32'd1);
        chk("done_rdata", resp_rdata, exp_rd);
        chk("done_en", {31'b0, mem_en}, 32'd0);
        chk("done_ready", {31'b0, req_ready}, 32'd0);
        step();
        chk("post_resp", {31'b0, resp_valid}, 32'd0);
        chk("post_ready", {31'b0, req_ready}, 32'd1);
        chk("post_hold", resp_rdata, exp_rd);
        chk("resp_count", resp_cnt - start_cnt, 32'd1);
    endtask

    initial begin
        total     = 0;
        fails     = 0;
        resp_cnt  = 0;
        en_cnt    = 0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h10] = 8'h44; ram[8'h11] = 8'h33; ram[8'h12] = 8'h22; ram[8'h13] = 8'h11;
        ram[8'hFE] = 8'h01; ram[8'hFF] = 8'h02; ram[8'h00] = 8'h03; ram[8'h01] = 8'h04;
        ram[8'h30] = 8'hA0; ram[8'h31] = 8'hA1; ram[8'h32] = 8'hA2; ram[8'h33] = 8'hA3;
        ram[8'h34] = 8'hB0; ram[8'h35] = 8'hB1; ram[8'h36] = 8'hB2; ram[8'h37] = 8'hB3;
        ram[8'h40] = 8'h55; ram[8'h41] = 8'h55; ram[8'h42] = 8'h55; ram[8'h43] = 8'h55;

        // Reset held with a pending request.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_en", {31'b0, mem_en}, 32'd0);
            chk("rst_ready", {31'b0, req_ready}, 32'd1);
            chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        end
        chk("rst_adr", {24'b0, mem_adr}, 32'd0);
        chk("rst_wdata", {24'b0, mem_wdata}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_memwr", {31'b0, mem_write}, 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        step();
        chk("rst_no_access", en_cnt, 32'd0);
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Plain read.
        xact(1'b0, 8'h10, 32'h0, 32'h11223344);

        // Write returns the prior contents, then read back.
        xact(1'b1, 8'h20, 32'hDEADBEEF, 32'h00000000);
        chk("wr_ram20", {24'b0, ram[8'h20]}, 32'hEF);
        chk("wr_ram21", {24'b0, ram[8'h21]}, 32'hBE);
        chk("wr_ram22", {24'b0, ram[8'h22]}, 32'hAD);
        chk("wr_ram23", {24'b0, ram[8'h23]}, 32'hDE);
        xact(1'b0, 8'h20, 32'h0, 32'hDEADBEEF);

        // Address wrap.
        xact(1'b0, 8'hFE, 32'h0, 32'h04030201);

        // Back-to-back with req_valid held high.
        begin
            int c0;
            c0 = resp_cnt;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 8'h30;
            step();
            for (int k = 1; k <= 5; k++) begin
                req_addr = 8'h60 + 8'(k);
                chk("b2b_busy", {31'b0, req_ready}, 32'd0);
                step();
            end
            req_addr = 8'h34;
            chk("b2b_ready6", {31'b0, req_ready}, 32'd1);
            chk("b2b_first_resp", resp_cnt - c0, 32'd1);
            chk("b2b_first_rdata", resp_rdata, 32'hA3A2A1A0);
            step();
            req_valid = 1'b0;
            chk("b2b_second_adr", {24'b0, mem_adr}, 32'h34);
            chk("b2b_second_en", {31'b0, mem_en}, 32'd1);
            for (int k = 0; k < 4; k++) step();
            chk("b2b_second_resp", {31'b0, resp_valid}, 32'd1);
            chk("b2b_second_rdata", resp_rdata, 32'hB3B2B1B0);
            step();
            chk("b2b_resp_total", resp_cnt - c0, 32'd2);
        end

        // Reset during beat 1 of a write.
        begin
            int c0;
            c0 = resp_cnt;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 8'h40;
            req_wdata = 32'hAABBCCDD;
            step();
            req_valid = 1'b0;
            step();
            chk("abort_beat1_adr", {24'b0, mem_adr}, 32'h41);
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("abort_ready", {31'b0, req_ready}, 32'd1);
            chk("abort_en", {31'b0, mem_en}, 32'd0);
            chk("abort_memwr", {31'b0, mem_write}, 32'd0);
            chk("abort_adr", {24'b0, mem_adr}, 32'd0);
            chk("abort_wdata", {24'b0, mem_wdata}, 32'd0);
            chk("abort_rdata", resp_rdata, 32'd0);
            chk("abort_resp", {31'b0, resp_valid}, 32'd0);
            step();
            chk("abort_no_resp", resp_cnt - c0, 32'd0);
            chk("abort_ram40", {24'b0, ram[8'h40]}, 32'hDD);
            chk("abort_ram41", {24'b0, ram[8'h41]}, 32'hCC);
            chk("abort_ram42", {24'b0, ram[8'h42]}, 32'h55);
            chk("abort_ram43", {24'b0, ram[8'h43]}, 32'h55);
            xact(1'b0, 8'h40, 32'h0, 32'h5555CCDD);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
